instruction_fetch_unit: RTL and testbench

//   Fetch stage directly upstream of the 32-bit byte-addressed big-endian instruction ROM.

---
 rtl/instruction_fetch_unit_if.sv | 37 +++
 rtl/instruction_fetch_unit.sv | 89 ++++++++
 tb/tb_instruction_fetch_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - fetch stage bus: ROM read port, redirect input, decode handshake
// The master modport is the fetch unit; the slave modport is the ROM/decode side.
interface instruction_fetch_unit_if;
  logic        fetch_en;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  modport master (
    input  fetch_en,
    output rom_addr,
    input  rom_data,
    input  redirect_valid,
    input  redirect_pc,
    output inst_valid,
    input  inst_ready,
    output inst_data,
    output inst_pc
  );

  modport slave (
    output fetch_en,
    input  rom_addr,
    output rom_data,
    output redirect_valid,
    output redirect_pc,
    input  inst_valid,
    output inst_ready,
    input  inst_data,
    input  inst_pc
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC register, ROM address drive and {pc, word} fetch FIFO to decode
// Redirects take priority over everything and flush the FIFO in the same edge.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  instruction_fetch_unit_if.master   fetch_bus
);

  localparam int             AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]    LP_DEPTH   = (AW+1)'(DEPTH);
  localparam logic [AW:0]    LP_CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0]  LP_PTR_ONE = AW'(1);

  logic [31:0]   r_pc;
  logic [31:0]   r_mem_pc   [DEPTH];
  logic [31:0]   r_mem_data [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic          w_pop;
  logic          w_push;
  logic          w_redirect;
  logic [31:0]   w_redirect_pc;
  logic          w_not_empty;

  assign w_not_empty   = (r_count != '0);
  assign w_redirect    = fetch_bus.redirect_valid;
  assign w_redirect_pc = {fetch_bus.redirect_pc[31:2], 2'b00};
  assign w_pop         = w_not_empty & fetch_bus.inst_ready;
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign w_push        = fetch_bus.fetch_en & ~w_redirect & ((r_count < LP_DEPTH) | w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (w_redirect) begin
      r_pc <= w_redirect_pc;
    end else if (w_push) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  // Storage is reset so the head reads as zero until the first fetch lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_pc[i]   <= '0;
        r_mem_data[i] <= '0;
      end
    end else if (w_push) begin
      r_mem_pc[r_wr_ptr]   <= r_pc;
      r_mem_data[r_wr_ptr] <= fetch_bus.rom_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_redirect) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LP_CNT_ONE;
        2'b01:   r_count <= r_count - LP_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign fetch_bus.rom_addr   = r_pc;
  assign fetch_bus.inst_valid = w_not_empty;
  assign fetch_bus.inst_data  = r_mem_data[r_rd_ptr];
  assign fetch_bus.inst_pc    = r_mem_pc[r_rd_ptr];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit
// ROM word at byte address a is ((a>>2)+1)*32'h11111111, truncated to 32 bits.
module tb_instruction_fetch_unit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  instruction_fetch_unit_if bus();

  instruction_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .fetch_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [31:0] idx;
    idx = {2'b00, a[31:2]} + 32'd1;
    return idx * 32'h1111_1111;
  endfunction

  always_comb bus.rom_data = rom_word(bus.rom_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks           = 0;
    n_errors           = 0;
    rst                = 1'b1;
    bus.fetch_en       = 1'b0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    step();
    step();

    check("rst_rom_addr", bus.rom_addr, 32'h0);
    check("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("rst_data", bus.inst_data, 32'h0);
    check("rst_pc", bus.inst_pc, 32'h0);

    // streaming at full throughput
    bus.fetch_en   = 1'b1;
    bus.inst_ready = 1'b1;
    rst            = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("t1_valid%0d", k), {31'd0, bus.inst_valid}, 32'd1);
      check($sformatf("t1_pc%0d", k), bus.inst_pc, 32'(4 * k));
      check($sformatf("t1_data%0d", k), bus.inst_data, 32'(k + 1) * 32'h1111_1111);
    end

    // back-pressure from a fresh reset
    rst            = 1'b1;
    bus.inst_ready = 1'b0;
    step();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("t2_rom_addr_stop", bus.rom_addr, 32'h8);
    check("t2_valid", {31'd0, bus.inst_valid}, 32'd1);
    check("t2_head_pc", bus.inst_pc, 32'h0);
    check("t2_head_data", bus.inst_data, 32'h1111_1111);

    // full FIFO draining with simultaneous push and pop
    bus.inst_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t2_order_pc%0d", k), bus.inst_pc, 32'(4 * k));
      check($sformatf("t2_order_data%0d", k), bus.inst_data, 32'(k + 1) * 32'h1111_1111);
      step();
    end
    check("t5_rom_addr", bus.rom_addr, 32'h18);

    bus.fetch_en = 1'b0;
    check("t5_drain_pc0", bus.inst_pc, 32'h10);
    step();
    check("t5_hold_addr0", bus.rom_addr, 32'h18);
    check("t5_drain_valid1", {31'd0, bus.inst_valid}, 32'd1);
    check("t5_drain_pc1", bus.inst_pc, 32'h14);
    check("t5_drain_data1", bus.inst_data, 32'h6666_6666);
    step();
    check("t5_empty", {31'd0, bus.inst_valid}, 32'd0);
    check("t5_hold_addr1", bus.rom_addr, 32'h18);

    // redirect while full
    bus.fetch_en   = 1'b1;
    bus.inst_ready = 1'b0;
    step();
    step();
    step();
    check("t3_full_addr", bus.rom_addr, 32'h20);
    check("t3_full_head", bus.inst_pc, 32'h18);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0103;
    bus.inst_ready     = 1'b1;
    step();
    bus.redirect_valid = 1'b0;
    check("t3_flush_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("t3_rom_addr", bus.rom_addr, 32'h100);
    step();
    check("t3_new_valid", {31'd0, bus.inst_valid}, 32'd1);
    check("t3_new_pc", bus.inst_pc, 32'h100);
    check("t3_new_data", bus.inst_data, 32'h5555_5551);

    // PC wrap at the top of the address space
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    step();
    bus.redirect_valid = 1'b0;
    check("t4_rom_addr", bus.rom_addr, 32'hFFFF_FFFC);
    step();
    check("t4_pc", bus.inst_pc, 32'hFFFF_FFFC);
    check("t4_data", bus.inst_data, 32'h4000_0000);
    check("t4_wrap_addr", bus.rom_addr, 32'h0);
    step();
    check("t4_after_pc", bus.inst_pc, 32'h0);
    check("t4_after_data", bus.inst_data, 32'h1111_1111);

    // asynchronous reset between edges
    step();
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("t6_async_addr", bus.rom_addr, 32'h0);
    check("t6_async_pc", bus.inst_pc, 32'h0);
    step();
    rst = 1'b0;
    step();
    check("t6_refetch_valid", {31'd0, bus.inst_valid}, 32'd1);
    check("t6_refetch_pc0", bus.inst_pc, 32'h0);
    check("t6_refetch_data0", bus.inst_data, 32'h1111_1111);
    step();
    check("t6_refetch_pc1", bus.inst_pc, 32'h4);
    check("t6_refetch_data1", bus.inst_data, 32'h2222_2222);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
